// File: rtl/bus_regbank.sv
// bus_regbank: host parallel-bus bridge into the clk domain.
// RD/WR strobes are synchronised and edge-detected, so every register
// here runs on clk. Writes commit into NWR registers and reads return a
// snapshot taken from one of NRD sources. Illegal accesses raise bus_err.
//
// state   | meaning
// IDLE    | waiting for a strobe rise (also covers waiting for WR to fall)
// WCOMMIT | one cycle: commit d_q into the selected write register
// RHOLD   | entry cycle (oe_q=0) takes the snapshot, then drive until RD falls
module bus_regbank #(
    parameter int DW          = 16,
    parameter int AW          = 12,
    parameter int SEL_MSB     = 11,
    parameter int SEL_LSB     = 8,
    parameter int NRD         = 8,
    parameter int NWR         = 4,
    parameter int SYNC_STAGES = 2,
    parameter logic [NWR*DW-1:0] WR_RST = (NWR*DW)'(10000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     ADDR,
    input  logic              RD,
    input  logic              WR,
    inout  wire  [DW-1:0]     DATA,
    output logic [NRD-1:0]    cs,
    input  logic [NRD*DW-1:0] rddat,
    output logic [NWR*DW-1:0] otdata,
    output logic [NWR-1:0]    wr_pulse,
    output logic [NRD-1:0]    rd_pulse,
    output logic              bus_err
);

    localparam int SW = SEL_MSB - SEL_LSB + 1;

    typedef enum logic [1:0] {IDLE, WCOMMIT, RHOLD} state_t;

    state_t                 state_q;
    logic [SW-1:0]          a_q;
    logic [DW-1:0]          d_q;
    logic [SYNC_STAGES-1:0] rd_sync_q, wr_sync_q;
    logic                   rd_dly_q, wr_dly_q;
    logic                   rd_s, wr_s, rd_rise, wr_rise;
    logic [DW-1:0]          rd_hold_q;
    logic                   oe_q;
    logic [NWR*DW-1:0]      otdata_q;
    logic [NWR-1:0]         wr_pulse_q;
    logic [NRD-1:0]         rd_pulse_q;
    logic                   bus_err_q;
    logic [DW-1:0]          rd_sel_d;
    logic                   rd_sel_ok, wr_sel_ok;
    logic                   unused_addr;

    // Only the select field of ADDR is decoded; the rest is host-side address.
    assign unused_addr = ^ADDR;

    assign rd_s    = rd_sync_q[SYNC_STAGES-1];
    assign wr_s    = wr_sync_q[SYNC_STAGES-1];
    assign rd_rise = rd_s & ~rd_dly_q;
    assign wr_rise = wr_s & ~wr_dly_q;

    // Raw RD gates the driver so the bus is released the instant RD drops.
    assign DATA     = (RD && oe_q) ? rd_hold_q : {DW{1'bz}};
    assign otdata   = otdata_q;
    assign wr_pulse = wr_pulse_q;
    assign rd_pulse = rd_pulse_q;
    assign bus_err  = bus_err_q;

    // Chip selects: pure decode of the raw address field, no strobe gating.
    always_comb begin
        cs = '0;
        for (int k = 0; k < NRD; k++) begin
            cs[k] = (ADDR[SEL_MSB:SEL_LSB] == SW'(k));
        end
    end

    // Read-source mux and range checks on the registered select.
    always_comb begin
        rd_sel_d  = '0;
        rd_sel_ok = 1'b0;
        wr_sel_ok = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            if (a_q == SW'(k)) begin
                rd_sel_d  = rddat[k*DW +: DW];
                rd_sel_ok = 1'b1;
            end
        end
        for (int k = 0; k < NWR; k++) begin
            if (a_q == SW'(k)) begin
                wr_sel_ok = 1'b1;
            end
        end
    end

    // Input capture: address/data registers, strobe synchronisers and edge flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            d_q       <= '0;
            rd_sync_q <= '0;
            wr_sync_q <= '0;
            rd_dly_q  <= 1'b0;
            wr_dly_q  <= 1'b0;
        end else begin
            a_q       <= ADDR[SEL_MSB:SEL_LSB];
            d_q       <= DATA;
            rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], RD};
            wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], WR};
            rd_dly_q  <= rd_s;
            wr_dly_q  <= wr_s;
        end
    end

    // Transaction FSM with registered pulses, write registers and read snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            otdata_q   <= WR_RST;
            wr_pulse_q <= '0;
            rd_pulse_q <= '0;
            bus_err_q  <= 1'b0;
            rd_hold_q  <= '0;
            oe_q       <= 1'b0;
        end else begin
            wr_pulse_q <= '0;
            rd_pulse_q <= '0;
            bus_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr_rise || rd_rise) begin
                        if (wr_s && rd_s) begin
                            bus_err_q <= 1'b1;
                        end else if (wr_rise) begin
                            state_q <= WCOMMIT;
                        end else begin
                            state_q <= RHOLD;
                        end
                    end
                end
                WCOMMIT: begin
                    if (wr_sel_ok) begin
                        for (int k = 0; k < NWR; k++) begin
                            if (a_q == SW'(k)) begin
                                otdata_q[k*DW +: DW] <= d_q;
                                wr_pulse_q[k]        <= 1'b1;
                            end
                        end
                    end else begin
                        bus_err_q <= 1'b1;
                    end
                    if (rd_rise) begin
                        bus_err_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                RHOLD: begin
                    if (!oe_q) begin
                        oe_q <= 1'b1;
                        if (rd_sel_ok) begin
                            rd_hold_q <= rd_sel_d;
                            for (int k = 0; k < NRD; k++) begin
                                if (a_q == SW'(k)) begin
                                    rd_pulse_q[k] <= 1'b1;
                                end
                            end
                        end else begin
                            rd_hold_q <= '0;
                            bus_err_q <= 1'b1;
                        end
                    end else if (!rd_s) begin
                        oe_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                    if (wr_rise) begin
                        bus_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    oe_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_regbank.sv
// Directed bench for bus_regbank: reset, write latency, read snapshot,
// illegal selects, RD/WR collision and reset during a read.
// A pull-up on DATA makes a released bus read back as 16'hFFFF.
module tb_bus_regbank;

    localparam logic [63:0] RST_VAL = 64'h0000_0000_0000_2710;
    localparam logic [15:0] BUS_Z   = 16'hFFFF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [11:0]  ADDR;
    logic         RD, WR;
    wire  [15:0]  DATA;
    logic [7:0]   cs;
    logic [127:0] rddat;
    logic [63:0]  otdata;
    logic [3:0]   wr_pulse;
    logic [7:0]   rd_pulse;
    logic         bus_err;

    logic [15:0]  host_d;
    logic         host_oe;

    int n_checks = 0;
    int n_fail   = 0;
    int errs;
    logic [3:0]   wr_acc;
    logic [7:0]   rd_acc;

    assign DATA = host_oe ? host_d : 16'hzzzz;
    pullup pu[15:0] (DATA);

    always #5 clk = ~clk;

    bus_regbank dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ADDR     (ADDR),
        .RD       (RD),
        .WR       (WR),
        .DATA     (DATA),
        .cs       (cs),
        .rddat    (rddat),
        .otdata   (otdata),
        .wr_pulse (wr_pulse),
        .rd_pulse (rd_pulse),
        .bus_err  (bus_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge_s();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        ADDR    = '0;
        RD      = 1'b0;
        WR      = 1'b0;
        host_d  = '0;
        host_oe = 1'b0;
        rddat   = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                   16'h3333, 16'h2222, 16'h1111, 16'h0f0f};
        idle_n(3);
        #1;
        check("rst_otdata_async", otdata, RST_VAL);
        rst_n = 1'b1;
        idle_n(2);
        check("rst_otdata", otdata, RST_VAL);
        check("rst_data_z", DATA, BUS_Z);
        check("rst_wr_pulse", wr_pulse, 0);
        check("rst_rd_pulse", rd_pulse, 0);
        check("rst_bus_err", bus_err, 0);

        ADDR = 12'h300; #1;
        check("cs_sel3", cs, 8'h08);
        ADDR = 12'hF00; #1;
        check("cs_sel15", cs, 8'h00);

        // Write 0x1234 to slot 1, WR high for 6 clocks
        ADDR = 12'h100; host_d = 16'h1234; host_oe = 1'b1;
        idle_n(5);
        WR = 1'b1;
        repeat (3) edge_s();
        check("wr_before_edge4", otdata, RST_VAL);
        check("wr_pulse_before", wr_pulse, 0);
        edge_s();
        check("wr_edge4_otdata", otdata, 64'h0000_0000_1234_2710);
        check("wr_edge4_pulse", wr_pulse, 4'b0010);
        edge_s();
        check("wr_pulse_single", wr_pulse, 0);
        edge_s();
        check("wr_no_recommit", wr_pulse, 0);
        @(negedge clk);
        WR = 1'b0;
        idle_n(4);
        host_oe = 1'b0;
        check("wr_no_err", bus_err, 0);

        // Read slot 3 with a snapshot that must survive a source change
        rddat[63:48] = 16'hA5A5;
        ADDR = 12'h300;
        idle_n(5);
        RD = 1'b1;
        repeat (3) edge_s();
        check("rd_edge3_z", DATA, BUS_Z);
        edge_s();
        check("rd_edge4_data", DATA, 16'hA5A5);
        check("rd_edge4_pulse", rd_pulse, 8'h08);
        @(negedge clk);
        rddat[63:48] = 16'h0000;
        edge_s();
        check("rd_pulse_single", rd_pulse, 0);
        check("rd_snapshot_hold", DATA, 16'hA5A5);
        edge_s();
        check("rd_snapshot_hold2", DATA, 16'hA5A5);
        @(negedge clk);
        RD = 1'b0;
        #1;
        check("rd_release_z", DATA, BUS_Z);
        idle_n(4);

        // Illegal write select 5
        ADDR = 12'h500; host_d = 16'hBEEF; host_oe = 1'b1;
        idle_n(5);
        WR = 1'b1;
        errs = 0; wr_acc = '0;
        repeat (8) begin edge_s(); errs += int'(bus_err); wr_acc |= wr_pulse; end
        check("ill_wr_err_count", errs, 1);
        check("ill_wr_no_pulse", wr_acc, 0);
        @(negedge clk);
        WR = 1'b0;
        idle_n(4);
        host_oe = 1'b0;
        check("ill_wr_otdata", otdata, 64'h0000_0000_1234_2710);

        // Illegal read select 15
        ADDR = 12'hF00;
        idle_n(5);
        RD = 1'b1;
        errs = 0; rd_acc = '0;
        repeat (8) begin edge_s(); errs += int'(bus_err); rd_acc |= rd_pulse; end
        check("ill_rd_err_count", errs, 1);
        check("ill_rd_no_pulse", rd_acc, 0);
        check("ill_rd_data", DATA, 16'h0000);
        @(negedge clk);
        RD = 1'b0;
        idle_n(4);

        // RD and WR together
        ADDR = 12'h200;
        idle_n(5);
        RD = 1'b1; WR = 1'b1;
        errs = 0; wr_acc = '0; rd_acc = '0;
        repeat (8) begin edge_s(); errs += int'(bus_err); wr_acc |= wr_pulse; rd_acc |= rd_pulse; end
        check("both_err_count", errs, 1);
        check("both_no_wr", wr_acc, 0);
        check("both_no_rd", rd_acc, 0);
        check("both_data_z", DATA, BUS_Z);
        check("both_otdata", otdata, 64'h0000_0000_1234_2710);
        @(negedge clk);
        RD = 1'b0; WR = 1'b0;
        idle_n(4);

        // Reset during RHOLD
        rddat[63:48] = 16'h5A5A;
        ADDR = 12'h300;
        idle_n(5);
        RD = 1'b1;
        repeat (6) edge_s();
        check("rst_rd_data", DATA, 16'h5A5A);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_data_z", DATA, BUS_Z);
        check("rst_mid_otdata", otdata, RST_VAL);
        check("rst_mid_pulses", {wr_pulse, rd_pulse, bus_err}, 0);
        RD = 1'b0;
        idle_n(2);
        rst_n = 1'b1;
        idle_n(3);
        check("post_rst_otdata", otdata, RST_VAL);
        check("post_rst_data_z", DATA, BUS_Z);

        // Fresh write to slot 2 shows the FSM is back in IDLE
        ADDR = 12'h200; host_d = 16'h0F0F; host_oe = 1'b1;
        idle_n(5);
        WR = 1'b1;
        repeat (4) edge_s();
        check("post_rst_wr_otdata", otdata, 64'h0000_0F0F_0000_2710);
        check("post_rst_wr_pulse", wr_pulse, 4'b0100);
        @(negedge clk);
        WR = 1'b0;
        idle_n(4);
        host_oe = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
